// File: rtl/io_pkg.sv
// Shared definitions for the WS2812 LED chain controller: register offsets,
// FSM state encoding and elaboration/datapath helpers.
package io_pkg;

  localparam logic [15:0] OFF_CTRL   = 16'd0;
  localparam logic [15:0] OFF_BRIGHT = 16'd1;
  localparam logic [15:0] OFF_PIX    = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } rgb_state_t;

  // Rounded conversion of a duration to clock cycles, evaluated at elaboration.
  function automatic int dur_to_cyc(input longint hz, input longint dur, input longint unit_div);
    return int'((hz * dur + unit_div / 2) / unit_div);
  endfunction

  // Brightness scaling: (c * (br + 1)) >> 8, so br = 8'hFF passes c unchanged.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] p;
    p = {8'b0, c} * ({8'b0, br} + 16'd1);
    return 8'(p >> 8);
  endfunction

endpackage

// File: rtl/rgb_bit_tx.sv
// Single-bit WS2812 serialiser. A start pulse samples bit_val and drives the
// line high for T0H/T1H cycles, then low for the rest of the bit period.
// done is high on the final low cycle; a start in that same cycle chains the
// next bit with no gap.
module rgb_bit_tx #(
  parameter int T0H_CYC = 11,
  parameter int T1H_CYC = 22,
  parameter int BIT_CYC = 34
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic bit_val,
  output logic line,
  output logic high_end,
  output logic done
);

  localparam logic [15:0] T0H_M1 = 16'(T0H_CYC - 1);
  localparam logic [15:0] T1H_M1 = 16'(T1H_CYC - 1);
  localparam logic [15:0] L0_M1  = 16'(BIT_CYC - T0H_CYC - 1);
  localparam logic [15:0] L1_M1  = 16'(BIT_CYC - T1H_CYC - 1);

  logic        active;
  logic        in_high;
  logic        bit_q;
  logic [15:0] cnt;

  assign high_end = active & in_high & (cnt == 16'd0);
  assign done     = active & ~in_high & (cnt == 16'd0);

  // High phase then low phase, each timed by a down-counter to zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      active  <= 1'b0;
      in_high <= 1'b0;
      bit_q   <= 1'b0;
      cnt     <= 16'd0;
      line    <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      in_high <= 1'b1;
      bit_q   <= bit_val;
      cnt     <= bit_val ? T1H_M1 : T0H_M1;
      line    <= 1'b1;
    end else if (active) begin
      if (cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end else if (in_high) begin
        in_high <= 1'b0;
        line    <= 1'b0;
        cnt     <= bit_q ? L1_M1 : L0_M1;
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/io_rgb_chain.sv
// WS2812 LED chain controller with an IO-mapped register window.
// Optional feature macro: RGB_BRIGHTNESS_EN (per-byte brightness scaling).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line low, waiting for START
// ST_LOAD  | one cycle: fetch PIX[idx] as g,r,b and launch its first bit
// ST_HIGH  | high part of the current bit (timed in rgb_bit_tx)
// ST_LOW   | low part of the current bit; chain next bit or next pixel
// ST_LATCH | line low for the reset/latch time, then DONE
module io_rgb_chain
  import io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h1100,
  parameter int          NUM_PIX   = 8,
  parameter int          CLK_HZ    = 27_000_000,
  parameter int          T0H_NS    = 400,
  parameter int          T1H_NS    = 800,
  parameter int          BIT_NS    = 1250,
  parameter int          LATCH_US  = 80
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        io_r,
  input  logic        io_w,
  input  logic [15:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        irq,
  output logic        ws2812_o
);

  localparam int T0H_CYC   = dur_to_cyc(longint'(CLK_HZ), longint'(T0H_NS), 64'd1_000_000_000);
  localparam int T1H_CYC   = dur_to_cyc(longint'(CLK_HZ), longint'(T1H_NS), 64'd1_000_000_000);
  localparam int BIT_CYC   = dur_to_cyc(longint'(CLK_HZ), longint'(BIT_NS), 64'd1_000_000_000);
  localparam int LATCH_CYC = dur_to_cyc(longint'(CLK_HZ), longint'(LATCH_US), 64'd1_000_000);

  localparam int                IDX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PIX - 1);
  localparam logic [15:0]       TOP_OFF  = 16'(NUM_PIX + 1);
  localparam logic [31:0]       LATCH_M1 = 32'(LATCH_CYC - 1);

  if (BIT_CYC <= T1H_CYC) begin : g_bad_bit_time
    $error("bit period must be longer than the 1-bit high time");
  end
  if (T0H_CYC < 1 || LATCH_CYC < 1) begin : g_bad_short_time
    $error("0-bit high time and latch time must be at least one cycle");
  end
  if (NUM_PIX < 1 || NUM_PIX > 64) begin : g_bad_num_pix
    $error("NUM_PIX must be in 1..64");
  end

  // ---------------- address decode ----------------
  logic [15:0]      off;
  logic [15:0]      off_pix;
  logic             in_win;
  logic             is_pix;
  logic [IDX_W-1:0] pix_sel;
  logic             wr_ctrl;
  logic             wr_bright;
  logic             wr_pix;

  assign off       = io_addr - BASE_ADDR;
  assign off_pix   = off - OFF_PIX;
  assign in_win    = (off <= TOP_OFF);
  assign is_pix    = in_win && (off >= OFF_PIX);
  assign pix_sel   = off_pix[IDX_W-1:0];
  assign wr_ctrl   = io_w && (off == OFF_CTRL);
  assign wr_bright = io_w && (off == OFF_BRIGHT);
  assign wr_pix    = io_w && is_pix;

  // ---------------- registers ----------------
  logic [23:0]      pix [NUM_PIX];
  logic             irq_en;
  logic             done;
  logic [7:0]       bright_rd;
  rgb_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [4:0]       bit_cnt;
  logic [23:0]      shreg;
  logic [31:0]      latch_cnt;
  logic             busy;
  logic             frame_end;
  logic             start_req;

  assign busy      = (state != ST_IDLE);
  assign frame_end = (state == ST_LATCH) && (latch_cnt == 32'd0);
  assign start_req = wr_ctrl && io_wdata[0];
  assign irq       = done & irq_en;

  // Control flags and pixel memory; a DONE set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_en <= 1'b0;
      done   <= 1'b0;
      for (int i = 0; i < NUM_PIX; i++) pix[i] <= 24'd0;
    end else begin
      if (wr_ctrl) irq_en <= io_wdata[1];
      if (frame_end) done <= 1'b1;
      else if (wr_ctrl && io_wdata[2]) done <= 1'b0;
      if (wr_pix) pix[pix_sel] <= io_wdata[23:0];
    end
  end

`ifdef RGB_BRIGHTNESS_EN
  logic [7:0] bright;

  // Brightness register, full scale out of reset.
  always_ff @(posedge clk) begin
    if (!rstn) bright <= 8'hFF;
    else if (wr_bright) bright <= io_wdata[7:0];
  end

  assign bright_rd = bright;
`else
  assign bright_rd = 8'h00;
`endif

  // ---------------- read mux ----------------
  logic [31:0] rd_val;

  // Combinational read data from the address alone.
  always_comb begin
    rd_val = 32'd0;
    if (off == OFF_CTRL) rd_val = {29'd0, done, irq_en, busy};
    else if (off == OFF_BRIGHT) rd_val = {24'd0, bright_rd};
    else if (is_pix) rd_val = {8'd0, pix[pix_sel]};
  end

  assign io_rdata = in_win ? rd_val : 'z;

  // ---------------- pixel fetch ----------------
  logic [23:0] pix_cur;
  logic [7:0]  g_byte;
  logic [7:0]  r_byte;
  logic [7:0]  b_byte;
  logic [23:0] load_word;

  assign pix_cur = pix[idx];

`ifdef RGB_BRIGHTNESS_EN
  assign g_byte = scale_byte(pix_cur[15:8], bright);
  assign r_byte = scale_byte(pix_cur[7:0], bright);
  assign b_byte = scale_byte(pix_cur[23:16], bright);
`else
  assign g_byte = pix_cur[15:8];
  assign r_byte = pix_cur[7:0];
  assign b_byte = pix_cur[23:16];
`endif

  assign load_word = {g_byte, r_byte, b_byte};

  // ---------------- bit transmitter ----------------
  logic tx_start;
  logic tx_bit;
  logic tx_high_end;
  logic tx_done;
  logic more_bits;

  assign more_bits = (bit_cnt != 5'd23);
  assign tx_start  = (state == ST_LOAD) || ((state == ST_LOW) && tx_done && more_bits);
  assign tx_bit    = (state == ST_LOAD) ? load_word[23] : shreg[22];

  rgb_bit_tx #(
    .T0H_CYC(T0H_CYC),
    .T1H_CYC(T1H_CYC),
    .BIT_CYC(BIT_CYC)
  ) u_bit_tx (
    .clk     (clk),
    .rstn    (rstn),
    .start   (tx_start),
    .bit_val (tx_bit),
    .line    (ws2812_o),
    .high_end(tx_high_end),
    .done    (tx_done)
  );

  // ---------------- frame sequencer ----------------
  // Walks pixels and bits; bit timing is owned by rgb_bit_tx.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      bit_cnt   <= 5'd0;
      shreg     <= 24'd0;
      latch_cnt <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            idx   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shreg   <= load_word;
          bit_cnt <= 5'd0;
          state   <= ST_HIGH;
        end
        ST_HIGH: begin
          if (tx_high_end) state <= ST_LOW;
        end
        ST_LOW: begin
          if (tx_done) begin
            if (more_bits) begin
              bit_cnt <= bit_cnt + 5'd1;
              shreg   <= {shreg[22:0], 1'b0};
              state   <= ST_HIGH;
            end else if (idx != LAST_IDX) begin
              idx   <= idx + IDX_W'(1);
              state <= ST_LOAD;
            end else begin
              latch_cnt <= LATCH_M1;
              state     <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (latch_cnt == 32'd0) state <= ST_IDLE;
          else latch_cnt <= latch_cnt - 32'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{io_r, io_wdata[31:24], off_pix[15:IDX_W], wr_bright};

endmodule

// File: tb/tb_io_rgb_chain.sv
`timescale 1ns/1ps
module tb_io_rgb_chain;

  localparam logic [15:0] BASE   = 16'h1100;
  localparam int          NPIX   = 8;
  localparam int          TH0    = 8;     // 400 ns at 20 MHz
  localparam int          TH1    = 16;    // 800 ns
  localparam int          BITC   = 25;    // 1250 ns
  localparam int          LATCHC = 1600;  // 80 us

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        io_r = 1'b0;
  logic        io_w = 1'b0;
  logic [15:0] io_addr = BASE;
  logic [31:0] io_wdata = 32'd0;
  tri1  [31:0] io_rdata;
  logic        irq;
  logic        ws2812_o;

  io_rgb_chain #(
    .BASE_ADDR(BASE),
    .NUM_PIX  (NPIX),
    .CLK_HZ   (20_000_000)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .io_r    (io_r),
    .io_w    (io_w),
    .io_addr (io_addr),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .irq     (irq),
    .ws2812_o(ws2812_o)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;
  bit   exp_q[$];          // expected line level, one entry per cycle of a frame
  logic [23:0] pm [NPIX];  // model copy of the pixel registers
  logic [7:0]  bm;         // model copy of BRIGHT

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
    int p;
    p = int'(c) * (int'(br) + 1);
    return 8'(p / 256);
  endfunction

  // Expected waveform: per pixel one LOAD cycle, then 24 bits (g,r,b MSB
  // first) each TH high + (BITC-TH) low, then the latch period.
  function automatic void build_frame();
    logic [7:0] by [3];
    int th;
    exp_q.delete();
    for (int p = 0; p < NPIX; p++) begin
      by[0] = pm[p][15:8];
      by[1] = pm[p][7:0];
      by[2] = pm[p][23:16];
`ifdef RGB_BRIGHTNESS_EN
      for (int k = 0; k < 3; k++) by[k] = scale(by[k], bm);
`endif
      exp_q.push_back(1'b0);
      for (int k = 0; k < 3; k++) begin
        for (int b = 7; b >= 0; b--) begin
          th = by[k][b] ? TH1 : TH0;
          for (int c = 0; c < BITC; c++) exp_q.push_back(c < th);
        end
      end
    end
    for (int c = 0; c < LATCHC; c++) exp_q.push_back(1'b0);
  endfunction

  function automatic int model_ones();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i]) n++;
    return n;
  endfunction

  // Line level every cycle; BUSY whenever CTRL is being addressed.
  always @(negedge clk) begin
    bit e;
    bit eb;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        eb = 1'b1;
      end else begin
        e  = 1'b0;
        eb = 1'b0;
      end
      checks++;
      if (ws2812_o !== e) begin
        errors++;
        $display("FAIL line t=%0t: got %b expected %b", $time, ws2812_o, e);
      end
      if (io_addr == BASE) begin
        checks++;
        if (io_rdata[0] !== eb) begin
          errors++;
          $display("FAIL busy t=%0t: got %b expected %b", $time, io_rdata[0], eb);
        end
      end
    end
  end

  task automatic io_write(input logic [15:0] a, input logic [31:0] d);
    io_w = 1'b1;
    io_addr = a;
    io_wdata = d;
    @(posedge clk);
    #1;
    io_w = 1'b0;
    io_addr = BASE;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [31:0] exp);
    io_addr = a;
    #1;
    chk(nm, io_rdata, exp);
    io_addr = BASE;
  endtask

  task automatic hiz_chk(input string nm, input logic [15:0] a);
    bit hiz;
    io_addr = a;
    #1;
    hiz = (io_rdata === 32'hzzzz_zzzz) || (io_rdata === 32'hffff_ffff);
    checks++;
    if (!hiz) begin
      errors++;
      $display("FAIL %s: got %h expected high-impedance", nm, io_rdata);
    end
    io_addr = BASE;
  endtask

  task automatic wait_drain(input string nm, input int lim);
    int n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: frame still running after %0d cycles", nm, n);
      exp_q.delete();
    end
  endtask

  task automatic wait_size(input int sz);
    int n = 0;
    while (exp_q.size() > sz && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic write_all_pix();
    for (int p = 0; p < NPIX; p++) io_write(BASE + 16'(2 + p), {8'd0, pm[p]});
  endtask

  initial begin
    logic [23:0] new5;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", {31'd0, ws2812_o}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_ctrl", BASE, 32'd0);
`ifdef RGB_BRIGHTNESS_EN
    rd_chk("rst_bright", BASE + 16'd1, 32'h0000_00FF);
`else
    rd_chk("rst_bright", BASE + 16'd1, 32'd0);
`endif
    rd_chk("rst_pix0", BASE + 16'd2, 32'd0);
    rd_chk("rst_pix7", BASE + 16'd9, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk_en = 1'b1;
    for (int p = 0; p < NPIX; p++) pm[p] = 24'd0;
    bm = 8'hFF;

    // ---------------- frame 1: PIX0 = 0000FF ----------------
    pm[0] = 24'h0000FF;
    pm[7] = 24'h00A000;
    write_all_pix();
    rd_chk("pix0_rd", BASE + 16'd2, 32'h0000_00FF);
    rd_chk("pix7_rd", BASE + 16'd9, 32'h0000_A000);
    hiz_chk("rd_below", BASE - 16'd1);
    hiz_chk("rd_above", BASE + 16'd10);
    pm[7] = 24'd0;
    write_all_pix();

    io_write(BASE, 32'h1);
    build_frame();
    chk("model_len", 32'(exp_q.size()), 32'd6408);
    chk("model_ones", 32'(model_ones()), 32'd1600);
    chk("model_g7_end", {31'd0, exp_q[8]}, 32'd1);
    chk("model_g7_low", {31'd0, exp_q[9]}, 32'd0);
    chk("model_r7_end", {31'd0, exp_q[216]}, 32'd1);
    chk("model_r7_low", {31'd0, exp_q[217]}, 32'd0);
    chk("scale_half", {24'd0, scale(8'hFF, 8'h7F)}, 32'h7F);
    chk("scale_quarter", {24'd0, scale(8'h80, 8'h7F)}, 32'h40);
    wait_drain("frame1_end", 8000);
    rd_chk("f1_ctrl_done", BASE, 32'h4);
    chk("f1_irq_off", {31'd0, irq}, 32'd0);

    // ---------------- frame 2: irq, live pixel update, START while busy ----------------
    io_write(BASE, 32'h4);
    rd_chk("clr_done", BASE, 32'd0);
    pm[0] = 24'h123456; pm[1] = 24'hA5F00F; pm[2] = 24'h000001; pm[3] = 24'h800000;
    pm[4] = 24'hFFFFFF; pm[5] = 24'h0F0F0F; pm[6] = 24'h3C3C3C; pm[7] = 24'h010203;
    write_all_pix();
    new5 = 24'hC33C5A;
    io_write(BASE, 32'h3);
    pm[5] = new5;
    build_frame();
    repeat (50) @(posedge clk);
    #1;
    io_write(BASE + 16'd7, {8'd0, new5});
    repeat (2000) @(posedge clk);
    #1;
    io_write(BASE, 32'h3);
    chk("busy_irq_low", {31'd0, irq}, 32'd0);
    rd_chk("busy_ctrl", BASE, 32'h3);
    wait_size(1);
    io_write(BASE, 32'h6);
    rd_chk("set_beats_clr", BASE, 32'h6);
    chk("irq_on", {31'd0, irq}, 32'd1);
    io_write(BASE, 32'h4);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd_chk("f2_ctrl_clr", BASE, 32'd0);

    // ---------------- frame 3: brightness ----------------
    for (int p = 0; p < NPIX; p++) pm[p] = 24'd0;
    pm[0] = 24'h0000FF;
    write_all_pix();
    io_write(BASE + 16'd1, 32'h7F);
`ifdef RGB_BRIGHTNESS_EN
    bm = 8'h7F;
    rd_chk("bright_rd", BASE + 16'd1, 32'h7F);
`else
    rd_chk("bright_rd", BASE + 16'd1, 32'd0);
`endif
    io_write(BASE, 32'h1);
    build_frame();
`ifdef RGB_BRIGHTNESS_EN
    chk("model_r7_dim", {31'd0, exp_q[209]}, 32'd0);
`else
    chk("model_r7_dim", {31'd0, exp_q[209]}, 32'd1);
`endif
    wait_drain("frame3_end", 8000);
    rd_chk("f3_ctrl_done", BASE, 32'h4);
    io_write(BASE, 32'h4);

    // ---------------- frame 4: reset during pixel 3 ----------------
    for (int p = 0; p < NPIX; p++) pm[p] = 24'hFF00FF ^ 24'(p * 24'h010101);
    write_all_pix();
    io_write(BASE, 32'h3);
    build_frame();
    repeat (3 * 601 + 100) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rstn = 1'b1;
    for (int p = 0; p < NPIX; p++) pm[p] = 24'd0;
    bm = 8'hFF;
    chk("abort_line", {31'd0, ws2812_o}, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    rd_chk("abort_ctrl", BASE, 32'd0);
    for (int p = 0; p < NPIX; p++) rd_chk($sformatf("abort_pix%0d", p), BASE + 16'(2 + p), 32'd0);
`ifdef RGB_BRIGHTNESS_EN
    rd_chk("abort_bright", BASE + 16'd1, 32'h0000_00FF);
`else
    rd_chk("abort_bright", BASE + 16'd1, 32'd0);
`endif
    repeat (200) @(posedge clk);
    #1;
    rd_chk("abort_no_done", BASE, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_rgb_chain.md
IO_RGB_CHAIN -- requirements
Module: io_rgb_chain

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h1100, first IO address of the block.
REQ-002 SHALL have parameter NUM_PIX, default 8, range 1..64, pixels in the chain.
REQ-003 SHALL have parameter CLK_HZ, default 27_000_000, clk frequency in Hz.
REQ-004 SHALL have parameters T0H_NS=400, T1H_NS=800, BIT_NS=1250, LATCH_US=80, giving the line timing.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port io_r  input  1  IO read strobe.
REQ-008 SHALL have port io_w  input  1  IO write strobe.
REQ-009 SHALL have port io_addr  input  16  IO word address.
REQ-010 SHALL have port io_wdata  input  32  IO write data.
REQ-011 SHALL have port io_rdata  output  32  read data; high-impedance when io_addr is outside the block.
REQ-012 SHALL have port irq  output  1  level interrupt, high while DONE=1 and IRQ_EN=1.
REQ-013 SHALL have port ws2812_o  output  1  serial line to the first LED.

Function
REQ-014 Register map SHALL be: BASE+0 CTRL, BASE+1 BRIGHT, BASE+2..BASE+1+NUM_PIX PIX[i] = {8'b0,b[23:16],g[15:8],r[7:0]}.
REQ-015 CTRL write SHALL decode: bit0 START, bit1 IRQ_EN (stored), bit2 DONE clear (write-1-to-clear); CTRL read returns {29'b0,DONE,IRQ_EN,BUSY}.
REQ-016 io_rdata SHALL be combinational from io_addr, with no io_r qualification.
REQ-017 Register writes SHALL take effect on the clk edge with io_w=1.
REQ-018 FSM states SHALL be IDLE, LOAD, HIGH, LOW, LATCH; BUSY=1 in every state except IDLE.
REQ-019 IDLE->LOAD SHALL occur on the edge where START=1 is written; START while BUSY SHALL be ignored.
REQ-020 LOAD (1 cycle) SHALL latch PIX[idx] into a 24-bit shift register in order g,r,b, MSB first.
REQ-021 Per bit, HIGH SHALL drive ws2812_o=1 for TH cycles (T0H or T1H by bit value), then LOW drives 0 for BITC-TH cycles.
REQ-022 Cycle counts SHALL be round(CLK_HZ*NS/1e9) computed at elaboration; BITC > T1H SHALL be asserted at elaboration.
REQ-023 After bit 23, idx SHALL increment and go to LOAD; after the last pixel, go to LATCH.
REQ-024 LATCH SHALL hold ws2812_o=0 for round(CLK_HZ*LATCH_US/1e6) cycles, then enter IDLE and set DONE=1.
REQ-025 PIX writes during BUSY SHALL be accepted; a pixel not yet loaded SHALL transmit the new value.
REQ-026 A DONE clear and a DONE set in the same cycle SHALL leave DONE=1.
REQ-027 Writes to unmapped offsets inside the window SHALL be ignored and read as 0.

Reset
REQ-028 While rstn=0 at a clk edge: FSM=IDLE, idx=0, ws2812_o=0, DONE=0, IRQ_EN=0, BRIGHT=8'hFF, all PIX=0, irq=0.
REQ-029 Reset mid-frame SHALL abort the transmission immediately, with no latch period emitted.

Configuration
REQ-030 With RGB_BRIGHTNESS_EN defined, each colour byte c SHALL be sent as (c*(BRIGHT+1))>>8, computed in LOAD; BRIGHT=8'hFF is identity.
REQ-031 Without RGB_BRIGHTNESS_EN, BRIGHT SHALL read 0, writes to it SHALL be ignored, and bytes SHALL be sent unscaled.

Structure
REQ-032 Register offset constants and the FSM state enum SHALL live in a shared package io_pkg.
REQ-033 Bit timing (HIGH/LOW counters and the per-bit serialiser) SHALL be a sub-module rgb_bit_tx with a start/done handshake.

Verification
REQ-034 CLK_HZ=20_000_000, NUM_PIX=1, PIX0=24'h0000FF, START -> 24 bits g=00,r=FF,b=00; high widths 8 cycles for 0-bits and 16 cycles for 1-bits, 25-cycle period; then 1600 low cycles; DONE=1.
REQ-035 IRQ_EN=1, frame ends -> irq=1; write CTRL=4 -> irq=0 on the next cycle.
REQ-036 START written while BUSY -> no restart; total frame length is unchanged.
REQ-037 rstn=0 for one cycle during pixel 3 of 8 -> ws2812_o=0, CTRL reads 0, PIX reads 0.
REQ-038 With RGB_BRIGHTNESS_EN: BRIGHT=8'h7F, r=8'hFF -> 8'h7F transmitted; without the macro -> 8'hFF transmitted and BRIGHT reads 0.
REQ-039 Read io_addr=BASE-1 -> io_rdata=Z; read BASE+2+NUM_PIX -> Z.
